// File: rtl/dmem_wbuf_if.sv
// dmem_wbuf bus bundle: MEM-stage data port plus the SRAM read/write ports.
// The master side is the pipeline/SRAM environment; the slave side is the buffer.
interface dmem_wbuf_if #(
    parameter int SRAM_AW = 14
);
    logic [1:0]         proc2Dmem_command;
    logic [31:0]        proc2Dmem_addr;
    logic [31:0]        proc2mem_data;
    logic [31:0]        mem2proc_data;
    logic [SRAM_AW-1:0] sram_raddr;
    logic [31:0]        sram_rdata;
    logic               sram_wreq;
    logic [SRAM_AW-1:0] sram_waddr;
    logic [31:0]        sram_wdata;
    logic               sram_wgnt;

    modport master (
        output proc2Dmem_command,
        output proc2Dmem_addr,
        output proc2mem_data,
        output sram_rdata,
        output sram_wgnt,
        input  mem2proc_data,
        input  sram_raddr,
        input  sram_wreq,
        input  sram_waddr,
        input  sram_wdata
    );

    modport slave (
        input  proc2Dmem_command,
        input  proc2Dmem_addr,
        input  proc2mem_data,
        input  sram_rdata,
        input  sram_wgnt,
        output mem2proc_data,
        output sram_raddr,
        output sram_wreq,
        output sram_waddr,
        output sram_wdata
    );
endinterface

// File: rtl/dmem_wbuf.sv
// Posted-store write buffer with same-cycle store-to-load forwarding.
// Define DMEM_WBUF_STATS_EN to add stat_stores/stat_fwd/stat_drop counters.
module dmem_wbuf #(
    parameter int DEPTH   = 4,
    parameter int SRAM_AW = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    dmem_wbuf_if.slave              bus,
    output logic [$clog2(DEPTH):0]  wbuf_count,
    output logic                    wbuf_ovf
`ifdef DMEM_WBUF_STATS_EN
    ,
    output logic [31:0]             stat_stores,
    output logic [31:0]             stat_fwd,
    output logic [31:0]             stat_drop
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] BUS_LOAD  = 2'h1;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [SRAM_AW-1:0] ent_addr [DEPTH];
    logic [31:0]        ent_data [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic               is_load;
    logic               is_store;
    logic               drain;
    logic               enq;
    logic               drop;
    logic [SRAM_AW-1:0] ld_addr;
    logic               hit;
    logic [31:0]        fwd_data;
    logic [PW-1:0]      idx;
    logic               unused_addr;

    assign is_load  = bus.proc2Dmem_command == BUS_LOAD;
    assign is_store = bus.proc2Dmem_command == BUS_STORE;
    assign ld_addr  = bus.proc2Dmem_addr[SRAM_AW+1:2];
    assign unused_addr = ^{bus.proc2Dmem_addr[1:0],
                           bus.proc2Dmem_addr[31:SRAM_AW+2]};

    // A drain frees a slot at the same edge, so a full buffer still accepts.
    assign drain = (count != '0) && bus.sram_wgnt;
    assign enq   = is_store && ((count != FULL) || drain);
    assign drop  = is_store && !enq;

    // Walk oldest to youngest; the last match is the youngest store.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && ent_addr[idx] == ld_addr) begin
                hit      = 1'b1;
                fwd_data = ent_data[idx];
            end
        end
    end

    assign bus.mem2proc_data = !is_load ? 32'h0
                             : hit      ? fwd_data
                             :            bus.sram_rdata;
    assign bus.sram_raddr = ld_addr;
    assign bus.sram_wreq  = count != '0;
    assign bus.sram_waddr = ent_addr[head];
    assign bus.sram_wdata = ent_data[head];
    assign wbuf_count     = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wbuf_ovf <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent_addr[tail] <= ld_addr;
                ent_data[tail] <= bus.proc2mem_data;
                tail           <= tail + 1'b1;
            end
            if (drain)
                head <= head + 1'b1;
            if (enq && !drain)
                count <= count + 1'b1;
            else if (!enq && drain)
                count <= count - 1'b1;
            if (drop)
                wbuf_ovf <= 1'b1;
        end
    end

`ifdef DMEM_WBUF_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stores <= '0;
            stat_fwd    <= '0;
            stat_drop   <= '0;
        end else begin
            if (enq)
                stat_stores <= stat_stores + 1'b1;
            if (is_load && hit)
                stat_fwd <= stat_fwd + 1'b1;
            if (drop)
                stat_drop <= stat_drop + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf (DEPTH=4, SRAM_AW=14).
// SRAM writes are logged at each clock edge and compared in order at the end.
module tb_dmem_wbuf;
    localparam logic [1:0] C_NONE  = 2'h0;
    localparam logic [1:0] C_LOAD  = 2'h1;
    localparam logic [1:0] C_STORE = 2'h2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cnt;
    logic       ovf;
    int         nchk = 0;
    int         nerr = 0;
    int         nw;

    logic [13:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    logic [13:0] exp_a  [11];
    logic [31:0] exp_d  [11];

`ifdef DMEM_WBUF_STATS_EN
    logic [31:0] s_st;
    logic [31:0] s_fw;
    logic [31:0] s_dr;
`endif

    dmem_wbuf_if #(.SRAM_AW(14)) bus ();

    dmem_wbuf #(
        .DEPTH  (4),
        .SRAM_AW(14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .wbuf_count(cnt),
        .wbuf_ovf  (ovf)
`ifdef DMEM_WBUF_STATS_EN
        ,
        .stat_stores(s_st),
        .stat_fwd   (s_fw),
        .stat_drop  (s_dr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.sram_wreq && bus.sram_wgnt) begin
            wlog_a.push_back(bus.sram_waddr);
            wlog_d.push_back(bus.sram_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic g,
                         input logic [31:0] rd);
        bus.proc2Dmem_command = c;
        bus.proc2Dmem_addr    = a;
        bus.proc2mem_data     = d;
        bus.sram_wgnt         = g;
        bus.sram_rdata        = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_a[0]  = 14'h040; exp_d[0]  = 32'hDEADBEEF;
        exp_a[1]  = 14'h080; exp_d[1]  = 32'h1;
        exp_a[2]  = 14'h080; exp_d[2]  = 32'h2;
        exp_a[3]  = 14'h0C0; exp_d[3]  = 32'h3;
        exp_a[4]  = 14'h140; exp_d[4]  = 32'h5;
        for (int k = 0; k < 6; k++) begin
            exp_a[5+k] = 14'h400 + 14'(k);
            exp_d[5+k] = 32'hA0 + 32'(k);
        end

        rst = 1'b1;
        drive(C_NONE, 0, 0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(cnt), 0);
        check("rst_wreq", 32'(bus.sram_wreq), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_waddr", 32'(bus.sram_waddr), 0);
        check("rst_wdata", bus.sram_wdata, 0);
        rst = 1'b0;
        step();

        drive(C_STORE, 32'h100, 32'hDEADBEEF, 1'b0, 0);
        step();
        drive(C_LOAD, 32'h100, 0, 1'b0, 0);
        #2;
        check("st1_count", 32'(cnt), 1);
        check("st1_wreq", 32'(bus.sram_wreq), 1);
        check("st1_waddr", 32'(bus.sram_waddr), 32'h40);
        check("st1_wdata", bus.sram_wdata, 32'hDEADBEEF);
        check("fwd_next", bus.mem2proc_data, 32'hDEADBEEF);
        check("raddr", 32'(bus.sram_raddr), 32'h40);
        step();
        drive(C_NONE, 32'h100, 0, 1'b0, 32'h5A5A5A5A);
        #2;
        check("none_zero", bus.mem2proc_data, 0);
        step();

        drive(C_STORE, 32'h200, 32'h1, 1'b0, 0);
        step();
        drive(C_STORE, 32'h200, 32'h2, 1'b0, 0);
        step();
        drive(C_LOAD, 32'h200, 0, 1'b0, 32'h5A5A5A5A);
        #2;
        check("youngest", bus.mem2proc_data, 32'h2);
        check("count3", 32'(cnt), 3);
        drive(C_LOAD, 32'h204, 0, 1'b0, 32'h5A5A5A5A);
        #2;
        check("miss_sram", bus.mem2proc_data, 32'h5A5A5A5A);
        step();

        drive(C_STORE, 32'h300, 32'h3, 1'b0, 0);
        step();
        drive(C_STORE, 32'h400, 32'h4, 1'b0, 0);
        step();
        drive(C_LOAD, 32'h400, 0, 1'b0, 32'h11111111);
        #2;
        check("ovf_count", 32'(cnt), 4);
        check("ovf_set", 32'(ovf), 1);
        check("ovf_dropped", bus.mem2proc_data, 32'h11111111);
        step();
        drive(C_STORE, 32'h500, 32'h5, 1'b1, 0);
        step();
        drive(C_LOAD, 32'h500, 0, 1'b0, 0);
        #2;
        check("full_gnt_count", 32'(cnt), 4);
        check("full_gnt_ovf", 32'(ovf), 1);
        check("full_gnt_fwd", bus.mem2proc_data, 32'h5);
        check("full_gnt_head", 32'(bus.sram_waddr), 32'h80);
`ifdef DMEM_WBUF_STATS_EN
        check("stat_drop1", s_dr, 1);
`endif
        step();

        drive(C_NONE, 0, 0, 1'b1, 0);
        repeat (4) step();
        drive(C_NONE, 0, 0, 1'b0, 0);
        #2;
        check("drained_count", 32'(cnt), 0);
        check("drained_wreq", 32'(bus.sram_wreq), 0);

        for (int k = 0; k < 6; k++) begin
            drive(C_STORE, 32'h1000 + 32'(4*k), 32'hA0 + 32'(k),
                  (k % 2) == 1, 0);
            step();
        end
        drive(C_LOAD, 32'h1014, 0, 1'b0, 0);
        #2;
        check("wrap_count", 32'(cnt), 3);
        check("wrap_fwd5", bus.mem2proc_data, 32'hA5);
        drive(C_LOAD, 32'h100C, 0, 1'b0, 0);
        #1;
        check("wrap_fwd3", bus.mem2proc_data, 32'hA3);
        drive(C_LOAD, 32'h1008, 0, 1'b0, 32'hCAFE);
        #1;
        check("wrap_drained", bus.mem2proc_data, 32'hCAFE);
        drive(C_NONE, 0, 0, 1'b1, 0);
        step();
        drive(C_LOAD, 32'h1010, 0, 1'b1, 0);
        #2;
        check("pop_count", 32'(cnt), 2);
        check("pop_fwd", bus.mem2proc_data, 32'hA4);
        check("pop_waddr", 32'(bus.sram_waddr), 32'h404);
        step();
        check("popped_count", 32'(cnt), 1);
        drive(C_NONE, 0, 0, 1'b1, 0);
        step();
        check("empty_count", 32'(cnt), 0);

        check("wlog_len", wlog_a.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < wlog_a.size()) begin
                check($sformatf("wlog_a%0d", i), 32'(wlog_a[i]),
                      32'(exp_a[i]));
                check($sformatf("wlog_d%0d", i), wlog_d[i], exp_d[i]);
            end
        end

        drive(C_STORE, 32'h2000, 32'h77, 1'b0, 0);
        step();
        drive(C_STORE, 32'h2004, 32'h78, 1'b0, 0);
        step();
        drive(C_STORE, 32'h2008, 32'h79, 1'b0, 0);
        step();
        drive(C_NONE, 0, 0, 1'b0, 0);
        #2;
        check("pre_rst_count", 32'(cnt), 3);
        nw = wlog_a.size();
        drive(C_NONE, 0, 0, 1'b1, 0);
        #1;
        rst = 1'b1;
        #1;
        check("async_count", 32'(cnt), 0);
        check("async_wreq", 32'(bus.sram_wreq), 0);
        check("async_ovf", 32'(ovf), 0);
        repeat (2) step();
        check("rst_nowrite", wlog_a.size(), nw);
`ifdef DMEM_WBUF_STATS_EN
        check("stat_stores0", s_st, 0);
        check("stat_fwd0", s_fw, 0);
        check("stat_drop0", s_dr, 0);
`endif
        rst = 1'b0;
        step();
        check("post_rst_count", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
